// File: rtl/uart_word_io_pkg.sv
// Shared definitions for the UART word adapter: word/byte widths, transfer
// size codes, default receive buffer depth and the controller state type.
package uart_word_io_pkg;

  localparam int LEN_WORD = 32;
  localparam int LEN_BYTE = 8;

  // Transfer size codes as seen on uart_size
  localparam logic [1:0] SIZE_1B     = 2'b00;
  localparam logic [1:0] SIZE_2B     = 2'b01;
  localparam logic [1:0] SIZE_4B     = 2'b10;
  localparam logic [1:0] SIZE_4B_ALT = 2'b11;

  localparam int DEFAULT_RX_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_RX   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Number of bytes moved for a given size code
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_1B:     return 3'd1;
      SIZE_2B:     return 3'd2;
      SIZE_4B:     return 3'd4;
      SIZE_4B_ALT: return 3'd4;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO. Reads are asynchronous from the storage array so the
// controller can consume a byte in the same cycle it decides to pop; a byte
// written in cycle t is visible from cycle t+1 (no write-to-read bypass).
module uart_rx_fifo
  import uart_word_io_pkg::*;
#(
  parameter int DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [LEN_BYTE-1:0]     push_data,
  input  logic                    pop,
  output logic [LEN_BYTE-1:0]     pop_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [LEN_BYTE-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [AW:0]         count_reg;
  logic                push_ok;
  logic                pop_ok;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_CNT);
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A full FIFO still takes a byte when a pop frees a slot in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage write; the array itself needs no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  // Occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_io.sv
// Word-to-byte adapter between a 32-bit request port and a byte-wide UART.
// Writes serialise the low n bytes of the word MSB-first; reads collect n
// bytes from the receive FIFO into a zero-extended word. Received bytes are
// buffered at all times, independent of any pending read.
module uart_word_io
  import uart_word_io_pkg::*;
#(
  parameter int RX_DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_order,
  input  logic [1:0]  uart_size,
  input  logic        uart_write,
  input  logic [31:0] uart_o_data,
  output logic        uart_accepted,
  output logic        uart_done,
  output logic [31:0] uart_r_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_overflow
);

  localparam int CNT_W = $clog2(RX_DEPTH) + 1;

  state_t              state_reg;
  state_t              state_next;
  logic [LEN_WORD-1:0] word_reg;
  logic [LEN_WORD-1:0] r_data_reg;
  logic [2:0]          rem_reg;
  logic                overflow_reg;

  logic [2:0]          bytes_req;
  logic [2:0]          lane_off;
  logic [LEN_WORD-1:0] tx_aligned;
  logic [LEN_WORD-1:0] rx_shifted;
  logic                last_byte;
  logic                tx_fire;
  logic                rx_drop;

  logic                fifo_pop;
  logic [LEN_BYTE-1:0] fifo_pop_data;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W-1:0]    unused_fifo_count;

  // Left-align the selected bytes so the first byte to send sits at the top
  // of the word; transmission then always takes word_reg[31:24] and shifts.
  assign bytes_req  = size_to_bytes(uart_size);
  assign lane_off   = 3'd4 - bytes_req;
  assign tx_aligned = uart_o_data << {lane_off, 3'b000};

  assign rx_shifted = {word_reg[LEN_WORD-LEN_BYTE-1:0], fifo_pop_data};
  assign last_byte  = (rem_reg == 3'd1);
  assign tx_fire    = tx_valid && tx_ready;

  // A byte is lost only if the FIFO is full and no slot frees this cycle
  assign rx_drop = rx_valid && fifo_full && !fifo_pop;

  assign tx_data     = word_reg[LEN_WORD-1 -: LEN_BYTE];
  assign uart_r_data = r_data_reg;
  assign rx_overflow = overflow_reg;

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (unused_fifo_count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; FIN always falls back to IDLE so orders are spaced by
  // at least one idle cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (uart_order) state_next = uart_write ? ST_TX : ST_RX;
      ST_TX:   if (tx_ready && last_byte) state_next = ST_FIN;
      ST_RX:   if (!fifo_empty && last_byte) state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs, all held low while reset is asserted
  always_comb begin
    uart_accepted = 1'b0;
    uart_done     = 1'b0;
    tx_valid      = 1'b0;
    fifo_pop      = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: uart_accepted = uart_order;
        ST_TX:   tx_valid      = 1'b1;
        ST_RX:   fifo_pop      = !fifo_empty;
        ST_FIN:  uart_done     = 1'b1;
        default: ;
      endcase
    end
  end

  // Shared shift register: shifts bytes out on writes, bytes in on reads
  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg <= '0;
      rem_reg  <= '0;
    end else if (uart_accepted) begin
      word_reg <= uart_write ? tx_aligned : '0;
      rem_reg  <= bytes_req;
    end else if (tx_fire) begin
      word_reg <= {word_reg[LEN_WORD-LEN_BYTE-1:0], {LEN_BYTE{1'b0}}};
      rem_reg  <= rem_reg - 3'd1;
    end else if (fifo_pop) begin
      word_reg <= rx_shifted;
      rem_reg  <= rem_reg - 3'd1;
    end
  end

  // Read result, loaded with the final byte so it is valid during FIN and
  // held until the next read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_reg <= '0;
    end else if (fifo_pop && last_byte) begin
      r_data_reg <= rx_shifted;
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (rx_drop) begin
      overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_word_io.sv
// Randomised bench for uart_word_io against a queue-based model of the
// receive buffer and an arithmetic model of byte ordering and latency.
`timescale 1ns/1ps
module tb_uart_word_io;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_order = 1'b0;
  logic [1:0]  uart_size = 2'b00;
  logic        uart_write = 1'b0;
  logic [31:0] uart_o_data = 32'h0;
  logic        uart_accepted;
  logic        uart_done;
  logic [31:0] uart_r_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned model_q[$];
  bit           exp_ovf = 1'b0;
  logic [31:0]  last_rdata = 32'h0;

  always #5 clk = ~clk;

  uart_word_io #(.RX_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_order    (uart_order),
    .uart_size     (uart_size),
    .uart_write    (uart_write),
    .uart_o_data   (uart_o_data),
    .uart_accepted (uart_accepted),
    .uart_done     (uart_done),
    .uart_r_data   (uart_r_data),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_overflow   (rx_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accepted and done must never coincide
  always @(negedge clk) begin
    check_eq("acc_done_excl", {31'd0, uart_accepted & uart_done}, 32'd0);
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Push one byte while no read is consuming the FIFO
  task automatic push_byte(input byte unsigned b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ovf = 1'b1;
    $display("[%0t] PUSH byte=0x%02h occupancy=%0d", $time, b, model_q.size());
  endtask

  // Wait (bounded) for the order to be accepted; returns one cycle later
  task automatic wait_accept(input string tag);
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      @(negedge clk);
      if (uart_accepted) seen = 1'b1;
      step();
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  // After done: done must drop, read data must hold
  task automatic post_done_checks();
    @(negedge clk);
    check_eq("done_single", {31'd0, uart_done}, 32'd0);
    check_eq("rdata_hold", uart_r_data, last_rdata);
    step();
  endtask

  // mode 0: tx_ready always 1, 1: ready on even cycles, 2: random ready
  task automatic do_write(input logic [1:0] size, input logic [31:0] data, input int mode);
    int n, cyc, last_hs, done_cyc;
    bit done_seen, hold_pending;
    logic [7:0] held;
    logic [31:0] gb;
    byte unsigned exp_bytes[$];
    byte unsigned got_bytes[$];
    n = size_bytes(size);
    for (int i = n - 1; i >= 0; i--) exp_bytes.push_back(8'((data >> (8 * i)) & 32'hFF));
    uart_order  = 1'b1;
    uart_write  = 1'b1;
    uart_size   = size;
    uart_o_data = data;
    wait_accept("wr_accepted");
    uart_order  = 1'b0;
    uart_o_data = $urandom;
    cyc = 1; last_hs = 0; done_cyc = 0;
    done_seen = 1'b0; hold_pending = 1'b0; held = 8'h0;
    while (!done_seen && cyc < 100) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (hold_pending && tx_valid) check_eq("wr_hold", {24'd0, tx_data}, {24'd0, held});
      hold_pending = 1'b0;
      if (uart_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end else if (tx_valid && tx_ready) begin
        got_bytes.push_back(tx_data);
        last_hs = cyc;
      end else if (tx_valid) begin
        hold_pending = 1'b1;
        held = tx_data;
      end
      step();
      cyc++;
    end
    tx_ready = 1'b0;
    check_eq("wr_done_seen", {31'd0, done_seen}, 32'd1);
    check_eq("wr_nbytes", got_bytes.size(), n);
    for (int i = 0; i < n; i++) begin
      gb = (i < got_bytes.size()) ? {24'd0, got_bytes[i]} : 32'hFFFF_FFFF;
      check_eq($sformatf("wr_byte%0d", i), gb, {24'd0, exp_bytes[i]});
    end
    check_eq("wr_done_after_last", done_cyc, last_hs + 1);
    if (mode == 0) check_eq("wr_latency", done_cyc, n + 1);
    $display("[%0t] WRITE size=%0d data=0x%08h mode=%0d bytes=%0d done@c%0d",
             $time, size, data, mode, got_bytes.size(), done_cyc);
    post_done_checks();
  endtask

  // late_delay > 0 injects late_byte on rx_valid at that cycle after accept
  task automatic do_read(input logic [1:0] size, input int late_delay, input byte unsigned late_byte);
    int n, cyc, done_cyc;
    bit done_seen, had_enough;
    logic [31:0] got, exp_w;
    n = size_bytes(size);
    had_enough = (model_q.size() >= n);
    uart_order = 1'b1;
    uart_write = 1'b0;
    uart_size  = size;
    uart_o_data = $urandom;
    wait_accept("rd_accepted");
    uart_order = 1'b0;
    cyc = 1; done_cyc = 0; done_seen = 1'b0; got = 32'h0;
    while (!done_seen && cyc < 100) begin
      if (late_delay > 0 && cyc == late_delay) begin
        rx_valid = 1'b1;
        rx_data  = late_byte;
      end else begin
        rx_valid = 1'b0;
      end
      @(negedge clk);
      if (uart_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        got       = uart_r_data;
      end
      step();
      if (rx_valid) model_q.push_back(late_byte);
      rx_valid = 1'b0;
      cyc++;
    end
    exp_w = 32'h0;
    for (int i = 0; i < n && model_q.size() > 0; i++) exp_w = {exp_w[23:0], model_q.pop_front()};
    check_eq("rd_done_seen", {31'd0, done_seen}, 32'd1);
    check_eq("rd_word", got, exp_w);
    if (had_enough) check_eq("rd_latency", done_cyc, n + 1);
    else if (late_delay > 0) check_eq("rd_late_latency", done_cyc, late_delay + 2);
    last_rdata = exp_w;
    $display("[%0t] READ size=%0d word=0x%08h done@c%0d", $time, size, got, done_cyc);
    post_done_checks();
  endtask

  initial begin
    logic [1:0] sz;
    int op;

    // Reset, with a byte offered during reset that must be discarded
    repeat (3) step();
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    step();
    rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_accepted", {31'd0, uart_accepted}, 32'd0);
    check_eq("rst_done", {31'd0, uart_done}, 32'd0);
    check_eq("rst_r_data", uart_r_data, 32'd0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_overflow", {31'd0, rx_overflow}, 32'd0);
    step();

    // Directed: 4-byte write, ready always high
    do_write(2'b10, 32'h1122_3344, 0);

    // Directed: 4-byte read of pre-buffered bytes
    push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
    do_read(2'b10, 0, 8'h00);

    // Directed: 1-byte read with the byte arriving 20 cycles after accept
    do_read(2'b00, 20, 8'h5A);
    check_eq("ovf_before_fill", {31'd0, rx_overflow}, 32'd0);

    // Directed: overfill the FIFO, then read back in order
    for (int i = 0; i < 9; i++) push_byte(8'(8'h60 + i));
    check_eq("ovf_after_fill", {31'd0, rx_overflow}, {31'd0, exp_ovf});
    do_read(2'b10, 0, 8'h00);
    do_read(2'b11, 0, 8'h00);

    // Directed: 2-byte write with ready toggling
    do_write(2'b01, 32'h0000_AABB, 1);

    // Randomised mix of pushes, writes and reads
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      case (op)
        0: repeat ($urandom_range(1, 3)) push_byte(8'($urandom));
        1: do_write(2'($urandom_range(0, 3)), $urandom, 2);
        default: begin
          sz = 2'($urandom_range(0, 3));
          while (model_q.size() < size_bytes(sz)) push_byte(8'($urandom));
          do_read(sz, 0, 8'h00);
        end
      endcase
      check_eq("ovf_sticky", {31'd0, rx_overflow}, {31'd0, exp_ovf});
    end

    // Reset in the middle of a write, with bytes buffered and rx_valid high
    push_byte(8'h31);
    push_byte(8'h32);
    uart_order  = 1'b1;
    uart_write  = 1'b1;
    uart_size   = 2'b10;
    uart_o_data = 32'hCAFE_F00D;
    tx_ready    = 1'b1;
    wait_accept("abort_accepted");
    uart_order = 1'b0;
    @(negedge clk);
    check_eq("abort_byte0", {24'd0, tx_data}, 32'h0000_00CA);
    step();
    @(negedge clk);
    check_eq("abort_byte1", {24'd0, tx_data}, 32'h0000_00FE);
    step();
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    @(negedge clk);
    check_eq("abort_done_in_rst", {31'd0, uart_done}, 32'd0);
    check_eq("abort_tx_valid_in_rst", {31'd0, tx_valid}, 32'd0);
    step();
    rst      = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    model_q.delete();
    exp_ovf    = 1'b0;
    last_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", {31'd0, uart_done}, 32'd0);
      check_eq("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
      check_eq("abort_tx_data", {24'd0, tx_data}, 32'd0);
      check_eq("abort_overflow", {31'd0, rx_overflow}, 32'd0);
      check_eq("abort_r_data", uart_r_data, 32'd0);
      step();
    end
    $display("[%0t] ABORT write reset after two bytes", $time);
    do_read(2'b00, 3, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
